write_address_queue_master: RTL and testbench
=============================================

WRITE_ADDRESS_QUEUE_MASTER -- requirements
Module: write_address_queue_master

Interface
REQ-001 Parameter ADDR_W, default 32: address width.
REQ-002 Parameter DEPTH, default 4: request queue entries; power of 2, at least 2.
REQ-003 Parameter MAX_OUTSTANDING, default 8: in-flight write-address limit; at least 1.
REQ-004 ACLK  in  1  single clock; all state updates on the rising edge.
REQ-005 ARESETn  in  1  asynchronous active-low reset.
REQ-006 i_req_valid  in  1  upstream request valid.
REQ-007 o_req_ready  out  1  queue can accept a request.
REQ-008 i_req_addr  in  ADDR_W  request address.
REQ-009 i_req_prot  in  3  request protection attributes.
REQ-010 o_AWVALID  out  1  AXI4-Lite write-address valid.
REQ-011 i_AWREADY  in  1  AXI4-Lite write-address ready.
REQ-012 o_AWADDR  out  ADDR_W  AXI4-Lite write address.
REQ-013 o_AWPROT  out  3  AXI4-Lite write protection.
REQ-014 i_b_done  in  1  one-cycle pulse per completed B handshake (BVALID&BREADY).
REQ-015 o_inflight  out  clog2(MAX_OUTSTANDING+1)  current in-flight count.
REQ-016 o_level  out  clog2(DEPTH+1)  queue occupancy.
REQ-017 o_underflow_err  out  1  sticky flag: i_b_done received with zero in flight.

Function
REQ-018 The block SHALL accept a request when i_req_valid and o_req_ready are both 1 at a rising edge, writing {addr,prot} into the FIFO.
REQ-019 o_req_ready SHALL be 1 exactly when o_level < DEPTH; when full, a same-cycle pop SHALL NOT enable a push (no full-bypass).
REQ-020 The output stage SHALL have two states: IDLE (o_AWVALID=0) and PRESENT (o_AWVALID=1, o_AWADDR/o_AWPROT held from the loaded entry).
REQ-021 Load condition: queue not empty and o_inflight < MAX_OUTSTANDING.
REQ-022 IDLE->PRESENT: when the load condition holds, the block SHALL pop the head entry into the output registers.
REQ-023 PRESENT with i_AWREADY=1: if the load condition holds, the block SHALL load the next entry and stay in PRESENT (back-to-back, no bubble); otherwise it SHALL return to IDLE.
REQ-024 PRESENT with i_AWREADY=0: o_AWVALID, o_AWADDR and o_AWPROT SHALL stay stable until the handshake completes.
REQ-025 o_AWVALID SHALL NOT depend combinationally on i_AWREADY.
REQ-026 o_AWADDR and o_AWPROT SHALL be 0 in IDLE.
REQ-027 Latency: a request accepted at edge N into an empty queue, with IDLE and credit available, SHALL give o_AWVALID=1 after edge N+1.
REQ-028 o_inflight SHALL increment on each load and decrement on each i_b_done.
REQ-029 Simultaneous load and i_b_done SHALL leave o_inflight unchanged.
REQ-030 The load condition SHALL use the registered o_inflight; an i_b_done in the same cycle SHALL NOT create credit for that cycle.
REQ-031 i_b_done with o_inflight=0 SHALL leave the count at 0 and set o_underflow_err.
REQ-032 Simultaneous push and pop SHALL leave o_level unchanged.
REQ-033 FIFO pointers SHALL wrap modulo DEPTH.
REQ-034 Entries SHALL issue in strict FIFO order.

Reset
REQ-035 When ARESETn is low, the block SHALL asynchronously clear: o_AWVALID, o_AWADDR, o_AWPROT, o_inflight, o_level, o_underflow_err, FIFO pointers and state (state returns to IDLE).
REQ-036 While ARESETn is low, o_req_ready SHALL be 0.
REQ-037 A reset mid-transaction SHALL discard all queued and presented entries without completing any handshake.

Structure
REQ-038 Package axi_lite_pkg SHALL hold the prot_t (3-bit) typedef, the state enum {IDLE, PRESENT} and the default parameter constants.
REQ-039 The FIFO SHALL be a sub-module, aw_req_fifo, parametrised by width (ADDR_W+3) and DEPTH.

Verification
REQ-040 Single request: push 0x0000_1000, prot=3'b010 with AWREADY=1 -> o_AWVALID=1 one edge later with AWADDR=0x1000, AWPROT=2; then IDLE, o_inflight=1.
REQ-041 Backpressure: hold AWREADY=0 for 5 cycles -> AWVALID, AWADDR and AWPROT stable for all 5 cycles; handshake on cycle 6.
REQ-042 Full queue: push 5 entries with AWREADY=0 and DEPTH=4 -> 1 entry presented, 4 queued, o_req_ready=0; then AWREADY=1 -> 5 back-to-back handshakes in order, no bubbles.
REQ-043 Credit limit: MAX_OUTSTANDING=2, 3 requests, no i_b_done -> only 2 handshakes; one i_b_done pulse -> third issued on the following cycle; simultaneous load and b_done -> o_inflight unchanged.
REQ-044 Error and reset: i_b_done with o_inflight=0 -> o_underflow_err=1 and held; assert ARESETn=0 while PRESENT -> o_AWVALID=0 immediately, o_level=0 and o_underflow_err=0.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared types and default sizing for the AXI4-Lite write-address request path.
package axi_lite_pkg;

  localparam int unsigned PROT_W              = 3;
  localparam int unsigned DEF_ADDR_W          = 32;
  localparam int unsigned DEF_DEPTH           = 4;
  localparam int unsigned DEF_MAX_OUTSTANDING = 8;

  typedef logic [PROT_W-1:0] prot_t;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } aw_state_e;

endpackage

// File: rtl/write_address_queue_master_if.sv
// Upstream request handshake plus the AXI4-Lite AW channel driven by the queue master.
interface write_address_queue_master_if
  import axi_lite_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W
);

  logic              i_req_valid;
  logic              o_req_ready;
  logic [ADDR_W-1:0] i_req_addr;
  prot_t             i_req_prot;

  logic              o_AWVALID;
  logic              i_AWREADY;
  logic [ADDR_W-1:0] o_AWADDR;
  prot_t             o_AWPROT;

  // The queue master: consumes requests, drives the AW channel.
  modport master (
    input  i_req_valid, i_req_addr, i_req_prot, i_AWREADY,
    output o_req_ready, o_AWVALID, o_AWADDR, o_AWPROT
  );

  // The surrounding environment: request producer and AW slave.
  modport slave (
    output i_req_valid, i_req_addr, i_req_prot, i_AWREADY,
    input  o_req_ready, o_AWVALID, o_AWADDR, o_AWPROT
  );

endinterface

// File: rtl/aw_req_fifo.sv
// Circular request FIFO; head is visible combinationally so the output stage can load it.
module aw_req_fifo #(
  parameter int unsigned WIDTH = 35,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         ACLK,
  input  logic                         ARESETn,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wdata,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head_c,
  output logic                         empty_c,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic             push_ok;
  logic             pop_ok;

  // Guard against overfill/underrun even if the caller misbehaves.
  assign push_ok = push && (level_q < LW'(DEPTH));
  assign pop_ok  = pop && (level_q != '0);

  always_ff @(posedge ACLK) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      level_q <= level_q + LW'(push_ok) - LW'(pop_ok);
    end
  end

  assign head_c  = mem[rd_ptr_q];
  assign empty_c = (level_q == '0);
  assign level   = level_q;

endmodule

// File: rtl/write_address_queue_master.sv
// Queues write-address requests and issues them on AXI4-Lite AW under an outstanding-credit limit.
module write_address_queue_master
  import axi_lite_pkg::*;
#(
  parameter int unsigned ADDR_W          = DEF_ADDR_W,
  parameter int unsigned DEPTH           = DEF_DEPTH,
  parameter int unsigned MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
  input  logic                                   ACLK,
  input  logic                                   ARESETn,
  write_address_queue_master_if.master           bus,
  input  logic                                   i_b_done,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   o_inflight,
  output logic [$clog2(DEPTH+1)-1:0]             o_level,
  output logic                                   o_underflow_err
);

  localparam int unsigned IW = $clog2(MAX_OUTSTANDING+1);
  localparam int unsigned LW = $clog2(DEPTH+1);
  localparam int unsigned EW = ADDR_W + PROT_W;

  // Elaboration-time parameter sanity.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two and at least 2");
  end
  if (MAX_OUTSTANDING < 1) begin : g_bad_max
    $error("MAX_OUTSTANDING must be at least 1");
  end

  aw_state_e         state_q;
  aw_state_e         state_d;
  logic [ADDR_W-1:0] aw_addr_q;
  logic [ADDR_W-1:0] aw_addr_d;
  prot_t             aw_prot_q;
  prot_t             aw_prot_d;
  logic [IW-1:0]     inflight_q;
  logic [IW-1:0]     inflight_d;
  logic              underflow_q;
  logic              underflow_d;

  logic              push_c;
  logic              load_c;
  logic              can_load_c;
  logic              b_valid_c;
  logic [EW-1:0]     head_c;
  logic              empty_c;

  // A full queue never accepts, even if the head leaves this cycle.
  assign push_c = bus.i_req_valid && (o_level < LW'(DEPTH));

  aw_req_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .push    (push_c),
    .wdata   ({bus.i_req_addr, bus.i_req_prot}),
    .pop     (load_c),
    .head_c  (head_c),
    .empty_c (empty_c),
    .level   (o_level)
  );

  // Credit is judged on the registered count; a same-cycle completion does not help.
  assign can_load_c = !empty_c && (inflight_q < IW'(MAX_OUTSTANDING));

  // Output-stage next state: load the head, hold under backpressure, or drop to IDLE.
  always_comb begin
    state_d   = state_q;
    aw_addr_d = aw_addr_q;
    aw_prot_d = aw_prot_q;
    load_c    = 1'b0;
    case (state_q)
      IDLE: begin
        if (can_load_c) begin
          load_c                 = 1'b1;
          state_d                = PRESENT;
          {aw_addr_d, aw_prot_d} = head_c;
        end
      end
      PRESENT: begin
        if (bus.i_AWREADY) begin
          if (can_load_c) begin
            load_c                 = 1'b1;
            {aw_addr_d, aw_prot_d} = head_c;
          end else begin
            state_d   = IDLE;
            aw_addr_d = '0;
            aw_prot_d = '0;
          end
        end
      end
    endcase
  end

  // A completion with nothing in flight is an error and does not touch the count.
  assign b_valid_c = i_b_done && (inflight_q != '0);

  always_comb begin
    inflight_d  = inflight_q;
    underflow_d = underflow_q;
    if (i_b_done && (inflight_q == '0)) begin
      underflow_d = 1'b1;
    end
    case ({load_c, b_valid_c})
      2'b10:   inflight_d = inflight_q + IW'(1);
      2'b01:   inflight_d = inflight_q - IW'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q     <= IDLE;
      aw_addr_q   <= '0;
      aw_prot_q   <= '0;
      inflight_q  <= '0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      aw_addr_q   <= aw_addr_d;
      aw_prot_q   <= aw_prot_d;
      inflight_q  <= inflight_d;
      underflow_q <= underflow_d;
    end
  end

  // Ready is forced low while reset is held.
  assign bus.o_req_ready = ARESETn && (o_level < LW'(DEPTH));
  assign bus.o_AWVALID   = (state_q == PRESENT);
  assign bus.o_AWADDR    = aw_addr_q;
  assign bus.o_AWPROT    = aw_prot_q;
  assign o_inflight      = inflight_q;
  assign o_underflow_err = underflow_q;

endmodule

// File: tb/tb_write_address_queue_master.sv
// Bench for write_address_queue_master: directed scenarios plus random traffic against a queue model.
module tb_write_address_queue_master;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned MAXO   = 2;
  localparam int unsigned IW     = $clog2(MAXO+1);
  localparam int unsigned LW     = $clog2(DEPTH+1);

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [2:0]        p;
  } ent_t;

  logic          ACLK;
  logic          ARESETn;
  logic          b_done;
  logic [IW-1:0] inflight;
  logic [LW-1:0] level;
  logic          underflow;

  write_address_queue_master_if #(.ADDR_W(ADDR_W)) bus ();

  write_address_queue_master #(
    .ADDR_W          (ADDR_W),
    .DEPTH           (DEPTH),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .ACLK            (ACLK),
    .ARESETn         (ARESETn),
    .bus             (bus),
    .i_b_done        (b_done),
    .o_inflight      (inflight),
    .o_level         (level),
    .o_underflow_err (underflow)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int n_cmp;
  int n_bad;
  int n_hs;

  // Reference model: a queue of waiting requests, one presented slot, a credit count.
  ent_t        m_q[$];
  ent_t        sb[$];
  bit          m_pres;
  ent_t        m_cur;
  int          m_infl;
  bit          m_err;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    sb.delete();
    m_pres = 1'b0;
    m_cur  = '0;
    m_infl = 0;
    m_err  = 1'b0;
  endtask

  function automatic void model_edge();
    bit   hs;
    bit   acc;
    bit   can;
    bit   ld;
    int   infl0;
    ent_t e;
    hs    = m_pres && (bus.i_AWREADY === 1'b1);
    acc   = (bus.i_req_valid === 1'b1) && (m_q.size() < DEPTH);
    can   = (m_q.size() > 0) && (m_infl < int'(MAXO));
    ld    = (!m_pres || hs) && can;
    infl0 = m_infl;
    if (ld) begin
      m_cur  = m_q.pop_front();
      m_pres = 1'b1;
      m_infl = m_infl + 1;
    end else if (hs) begin
      m_pres = 1'b0;
      m_cur  = '0;
    end
    if (b_done === 1'b1) begin
      if (infl0 > 0) m_infl = m_infl - 1;
      else           m_err  = 1'b1;
    end
    if (acc) begin
      e.a = bus.i_req_addr;
      e.p = bus.i_req_prot;
      m_q.push_back(e);
      sb.push_back(e);
    end
  endfunction

  task automatic compare_outputs();
    check_eq("awvalid",   64'(bus.o_AWVALID),   64'(m_pres));
    check_eq("awaddr",    64'(bus.o_AWADDR),    64'(m_cur.a));
    check_eq("awprot",    64'(bus.o_AWPROT),    64'(m_cur.p));
    check_eq("level",     64'(level),           64'(m_q.size()));
    check_eq("inflight",  64'(inflight),        64'(m_infl));
    check_eq("req_ready", 64'(bus.o_req_ready), 64'(m_q.size() < DEPTH));
    check_eq("underflow", 64'(underflow),       64'(m_err));
  endtask

  task automatic drive(input logic v, input logic [ADDR_W-1:0] a, input logic [2:0] p,
                       input logic rdy, input logic bd);
    bus.i_req_valid = v;
    bus.i_req_addr  = a;
    bus.i_req_prot  = p;
    bus.i_AWREADY   = rdy;
    b_done          = bd;
  endtask

  // One clock: note any AW handshake, advance the model, then compare 1 time unit later.
  task automatic tick();
    logic hs;
    ent_t seen;
    ent_t exp;
    hs     = bus.o_AWVALID && bus.i_AWREADY;
    seen.a = bus.o_AWADDR;
    seen.p = bus.o_AWPROT;
    @(posedge ACLK);
    model_edge();
    #1;
    if (hs) begin
      n_hs++;
      check_eq("hs_expected", 64'(sb.size() > 0), 64'(1));
      if (sb.size() > 0) begin
        exp = sb.pop_front();
        check_eq("hs_order", 64'(seen), 64'(exp));
      end
    end
    compare_outputs();
  endtask

  int hs0;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    n_hs  = 0;
    ARESETn = 1'b0;
    drive(0, '0, '0, 0, 0);
    model_reset();
    repeat (3) @(posedge ACLK);
    #1;
    check_eq("rst_ready",    64'(bus.o_req_ready), 64'(0));
    check_eq("rst_awvalid",  64'(bus.o_AWVALID),   64'(0));
    check_eq("rst_awaddr",   64'(bus.o_AWADDR),    64'(0));
    check_eq("rst_level",    64'(level),           64'(0));
    check_eq("rst_inflight", 64'(inflight),        64'(0));
    check_eq("rst_err",      64'(underflow),       64'(0));
    @(negedge ACLK);
    ARESETn = 1'b1;
    #1;
    check_eq("ready_after_rst", 64'(bus.o_req_ready), 64'(1));

    // Single request with AWREADY high.
    drive(1, 32'h0000_1000, 3'b010, 1, 0);
    tick();
    check_eq("t1_valid_edgeN", 64'(bus.o_AWVALID), 64'(0));
    drive(0, '0, '0, 1, 0);
    tick();
    check_eq("t1_valid_edgeN1", 64'(bus.o_AWVALID), 64'(1));
    check_eq("t1_addr",         64'(bus.o_AWADDR),  64'(32'h1000));
    check_eq("t1_prot",         64'(bus.o_AWPROT),  64'(2));
    tick();
    check_eq("t1_idle",     64'(bus.o_AWVALID), 64'(0));
    check_eq("t1_inflight", 64'(inflight),      64'(1));
    drive(0, '0, '0, 1, 1);
    tick();
    drive(0, '0, '0, 1, 0);
    check_eq("t1_drained", 64'(inflight), 64'(0));

    // Backpressure: five stalled cycles, handshake on the sixth.
    drive(1, 32'h0000_2000, 3'b101, 0, 0);
    tick();
    drive(0, '0, '0, 0, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      check_eq("t2_hold_valid", 64'(bus.o_AWVALID), 64'(1));
      check_eq("t2_hold_addr",  64'(bus.o_AWADDR),  64'(32'h2000));
      check_eq("t2_hold_prot",  64'(bus.o_AWPROT),  64'(5));
      tick();
    end
    hs0 = n_hs;
    drive(0, '0, '0, 1, 0);
    tick();
    check_eq("t2_one_hs", 64'(n_hs - hs0), 64'(1));
    check_eq("t2_idle",   64'(bus.o_AWVALID), 64'(0));
    drive(0, '0, '0, 1, 1);
    tick();
    drive(0, '0, '0, 0, 0);

    // Full queue: one presented, four queued, then drain back-to-back.
    for (int i = 0; i < 5; i++) begin
      drive(1, ADDR_W'(32'h3000 + i * 16), 3'(i), 0, 0);
      tick();
    end
    drive(0, '0, '0, 0, 0);
    check_eq("t3_level", 64'(level),           64'(4));
    check_eq("t3_ready", 64'(bus.o_req_ready), 64'(0));
    check_eq("t3_valid", 64'(bus.o_AWVALID),   64'(1));
    check_eq("t3_addr",  64'(bus.o_AWADDR),    64'(32'h3000));
    drive(1, 32'hDEAD_0000, 3'b111, 0, 0);
    tick();
    check_eq("t3_full_reject", 64'(level), 64'(4));
    hs0 = n_hs;
    drive(0, '0, '0, 1, 1);
    for (int i = 0; i < 5; i++) begin
      check_eq("t3_no_bubble", 64'(bus.o_AWVALID), 64'(1));
      tick();
    end
    drive(0, '0, '0, 1, 0);
    check_eq("t3_hs_count", 64'(n_hs - hs0), 64'(5));
    check_eq("t3_idle",     64'(bus.o_AWVALID), 64'(0));
    check_eq("t3_inflight", 64'(inflight),      64'(0));

    // Credit limit: three requests, only two may issue until a completion arrives.
    hs0 = n_hs;
    for (int i = 0; i < 3; i++) begin
      drive(1, ADDR_W'(32'h4000 + i * 4), 3'b001, 1, 0);
      tick();
    end
    drive(0, '0, '0, 1, 0);
    repeat (6) tick();
    check_eq("t4_two_hs",   64'(n_hs - hs0),    64'(2));
    check_eq("t4_inflight", 64'(inflight),      64'(2));
    check_eq("t4_level",    64'(level),         64'(1));
    check_eq("t4_stalled",  64'(bus.o_AWVALID), 64'(0));
    drive(0, '0, '0, 1, 1);
    tick();
    check_eq("t4_no_same_cycle_credit", 64'(bus.o_AWVALID), 64'(0));
    check_eq("t4_inflight_dec",         64'(inflight),      64'(1));
    drive(0, '0, '0, 1, 0);
    tick();
    check_eq("t4_third_valid", 64'(bus.o_AWVALID), 64'(1));
    check_eq("t4_third_addr",  64'(bus.o_AWADDR),  64'(32'h4008));
    tick();
    check_eq("t4_three_hs", 64'(n_hs - hs0), 64'(3));
    drive(0, '0, '0, 1, 1);
    repeat (2) tick();
    drive(0, '0, '0, 1, 0);
    check_eq("t4_drained", 64'(inflight), 64'(0));

    // Underflow is sticky; reset while presenting clears everything at once.
    drive(0, '0, '0, 0, 1);
    tick();
    check_eq("t5_err_set", 64'(underflow), 64'(1));
    check_eq("t5_cnt_0",   64'(inflight),  64'(0));
    drive(0, '0, '0, 0, 0);
    repeat (3) tick();
    check_eq("t5_err_held", 64'(underflow), 64'(1));
    drive(1, 32'h0000_5000, 3'b011, 0, 0);
    repeat (3) tick();
    drive(0, '0, '0, 0, 0);
    tick();
    check_eq("t5_presenting", 64'(bus.o_AWVALID), 64'(1));
    #2;
    ARESETn = 1'b0;
    #1;
    check_eq("t5_rst_awvalid",  64'(bus.o_AWVALID),   64'(0));
    check_eq("t5_rst_awaddr",   64'(bus.o_AWADDR),    64'(0));
    check_eq("t5_rst_level",    64'(level),           64'(0));
    check_eq("t5_rst_err",      64'(underflow),       64'(0));
    check_eq("t5_rst_inflight", 64'(inflight),        64'(0));
    check_eq("t5_rst_ready",    64'(bus.o_req_ready), 64'(0));
    model_reset();
    @(negedge ACLK);
    ARESETn = 1'b1;
    #1;
    tick();

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      drive(1'($urandom_range(0, 99) < 60), ADDR_W'($urandom), 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 99) < 70), 1'((m_infl > 0) && ($urandom_range(0, 99) < 35)));
      tick();
    end
    drive(0, '0, '0, 1, 0);
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
